// File: rtl/piso_tx.sv
// piso_tx: parallel-in serial-out frame transmitter. Sends start(0), data LSB-first, stop(1), one bit per tick.
// Optional feature macro PISO_TX_PARITY_EN inserts an even-parity bit between the data bits and the stop bit.
module piso_tx #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tick,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_data,
    output logic             sout,
    output logic             busy,
    output logic             done
);

`ifdef PISO_TX_PARITY_EN
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOADED = 3'd1,
        START  = 3'd2,
        DATA   = 3'd3,
        PARITY = 3'd4,
        STOP   = 3'd5
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOADED = 3'd1,
        START  = 3'd2,
        DATA   = 3'd3,
        STOP   = 3'd4
    } state_t;
`endif

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

    state_t           r_state;
    logic [WIDTH-1:0] r_sreg;
    logic [CNT_W-1:0] r_cnt;
    logic             r_sout;
    logic             r_busy;
    logic             r_done;
`ifdef PISO_TX_PARITY_EN
    logic             r_par;
`endif

    // Ready is decoded from state so it also reads 1 while reset holds the FSM in IDLE.
    assign load_ready = (r_state == IDLE);
    assign sout       = r_sout;
    assign busy       = r_busy;
    assign done       = r_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_sreg  <= '0;
            r_cnt   <= '0;
            r_sout  <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
`ifdef PISO_TX_PARITY_EN
            r_par   <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (load_valid) begin
                        r_sreg  <= load_data;
`ifdef PISO_TX_PARITY_EN
                        r_par   <= ^load_data;
`endif
                        r_busy  <= 1'b1;
                        r_state <= LOADED;
                    end
                end
                LOADED: begin
                    if (tick) begin
                        r_sout  <= 1'b0;
                        r_state <= START;
                    end
                end
                START: begin
                    if (tick) begin
                        r_sout  <= r_sreg[0];
                        r_sreg  <= r_sreg >> 1;
                        r_cnt   <= '0;
                        r_state <= DATA;
                    end
                end
                DATA: begin
                    if (tick) begin
                        if (r_cnt == LAST_IDX) begin
`ifdef PISO_TX_PARITY_EN
                            r_sout  <= r_par;
                            r_state <= PARITY;
`else
                            r_sout  <= 1'b1;
                            r_state <= STOP;
`endif
                        end else begin
                            r_sout <= r_sreg[0];
                            r_sreg <= r_sreg >> 1;
                            r_cnt  <= r_cnt + 1'b1;
                        end
                    end
                end
`ifdef PISO_TX_PARITY_EN
                PARITY: begin
                    if (tick) begin
                        r_sout  <= 1'b1;
                        r_state <= STOP;
                    end
                end
`endif
                STOP: begin
                    if (tick) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_sout  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
